line_mem_arbiter: RTL and testbench
===================================

Name: line_mem_arbiter

Overview:
- Sits directly downstream of the instruction cache and data cache; merges their cacheline-granular miss/writeback traffic onto the single physical-memory port (pmem_*) of the mp4 top.
- Serves one transaction at a time, with round-robin priority on simultaneous requests.
- Registers the returned line and a one-cycle response pulse back to the winning cache.

Parameters:
- LINE_W, 256, cacheline width in bits
- ADDR_W, 32, byte address width; line-aligned (low log2(LINE_W/8) bits ignored, forced to 0 on pmem_address)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- i_read  in  1  icache line-fill request, held until i_resp
- i_addr  in  ADDR_W  icache request address
- i_rdata  out  LINE_W  line returned to icache
- i_resp  out  1  one-cycle completion pulse to icache
- d_read  in  1  dcache line-fill request, held until d_resp
- d_write  in  1  dcache writeback request, held until d_resp; never asserted together with d_read
- d_addr  in  ADDR_W  dcache request address
- d_wdata  in  LINE_W  dcache writeback line
- d_rdata  out  LINE_W  line returned to dcache
- d_resp  out  1  one-cycle completion pulse to dcache
- pmem_read  out  1  memory read request
- pmem_write  out  1  memory write request
- pmem_address  out  ADDR_W  line-aligned memory address
- pmem_wdata  out  LINE_W  memory write line
- pmem_rdata  in  LINE_W  memory read line, valid with pmem_resp
- pmem_resp  in  1  memory completion, one cycle

Behaviour:
- Reset values (rst=0, asynchronous): state=IDLE, last_grant=I. i_resp, d_resp, pmem_read and pmem_write are 0; pmem_address, pmem_wdata, i_rdata and d_rdata are all 0.
- State machine states: IDLE, SERVE, RESP.
- IDLE:
  - Only i pending -> grant I.
  - Only d pending -> grant D.
  - Both pending -> grant the side that is not last_grant.
  - On grant: latch owner, latch op (read/write), latch address with low bits zeroed, and latch d_wdata if write. Go to SERVE next edge.
  - Nothing pending -> stay in IDLE.
- SERVE:
  - pmem_read or pmem_write is driven from the latched op; pmem_address and pmem_wdata come from the latches. All are stable for the whole state.
  - Requester inputs are not re-sampled.
  - On pmem_resp=1: capture pmem_rdata into the owner's rdata register (reads only; writes leave rdata unchanged), update last_grant=owner, go to RESP.
  - pmem_read and pmem_write are decoded from the registered state. They drop to 0 in the cycle after pmem_resp.
- RESP:
  - The owner's resp=1 for exactly one cycle; the other resp=0. Then go to IDLE.
  - The requester drops its request on the edge that ends RESP, so IDLE never re-grants a completed request.
- Latency: request first high in IDLE cycle N -> pmem request high from N+1. pmem_resp in cycle M -> owner resp in M+1 -> arbiter in IDLE at M+2. Minimum 3 cycles per transaction with a 1-cycle memory.
- rdata registers hold their value until the next read completes for the same owner.
- Mid-transaction request from the other cache: it waits in place, is not dropped, and is granted in the IDLE cycle after RESP.
- pmem_resp outside SERVE: ignored; no state or data change.
- Reset asserted mid-SERVE: immediately return to IDLE with all outputs cleared. The pending pmem transaction is abandoned; the caches are reset by the same signal.
- d_read and d_write both high: illegal; the bench flags it and the RTL treats it as a read.

Test Plan:
- I-only read: i_read=1, i_addr=0x0000_0064, memory answers 2 cycles later with line 0xAA..AA -> pmem_read=1 with pmem_address=0x0000_0060; i_rdata=0xAA..AA with i_resp a single pulse; d_resp stays 0.
- D writeback: d_write=1, d_addr=0x0000_1040, d_wdata=0x1234..5678 -> pmem_write=1 with address 0x1040 and matching wdata; d_resp pulses once; d_rdata unchanged.
- Simultaneous requests after reset (last_grant=I), i_addr=0x100, d_addr=0x200 -> D served first (pmem_address=0x200), then I (0x100). A second simultaneous pair is served I first, then D.
- Request arriving during SERVE: d_read asserted 1 cycle after an I grant -> it stays pending, is granted exactly 1 cycle after i_resp, and has no lost or duplicate pmem access.
- Async reset mid-SERVE: rst=0 between clock edges -> pmem_read drops to 0 without waiting for clk. After release, a stray pmem_resp produces no i_resp or d_resp.
- Stray pmem_resp in IDLE with random pmem_rdata -> no resp pulse; i_rdata and d_rdata unchanged.

Source files
------------

// File: rtl/line_mem_arbiter_if.sv
// Cache-side and memory-side line transfer signals of the line memory arbiter.
// The arbiter connects through the slave modport; the caches and memory use master.
interface line_mem_arbiter_if #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  i_read, i_addr,
        output i_rdata, i_resp,
        input  d_read, d_write, d_addr, d_wdata,
        output d_rdata, d_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output i_read, i_addr,
        input  i_rdata, i_resp,
        output d_read, d_write, d_addr, d_wdata,
        input  d_rdata, d_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/line_mem_arbiter.sv
// Merges icache and dcache line traffic onto one physical-memory port,
// one transaction at a time, round-robin on simultaneous requests.
module line_mem_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input logic                clk,
    input logic                rst,
    line_mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SERVE, RESP} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q;
    owner_t            last_q;
    logic              op_wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] i_rdata_q;
    logic [LINE_W-1:0] d_rdata_q;

    logic              d_req;
    logic              grant;
    logic              grant_d;
    logic              grant_wr;
    logic              capture;

    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(LINE_W / 8 - 1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Arbitration and sequencing; requester inputs only matter in IDLE.
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        grant_d = 1'b0;
        capture = 1'b0;
        d_req   = bus.d_read | bus.d_write;
        case (state_q)
            IDLE: begin
                if (bus.i_read && d_req) begin
                    grant   = 1'b1;
                    grant_d = (last_q == OWN_I);
                end else if (bus.i_read) begin
                    grant   = 1'b1;
                end else if (d_req) begin
                    grant   = 1'b1;
                    grant_d = 1'b1;
                end
                if (grant) state_d = SERVE;
            end
            SERVE: begin
                if (bus.pmem_resp) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A simultaneous d_read/d_write is resolved as a read.
    assign grant_wr = grant_d & bus.d_write & ~bus.d_read;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q   <= OWN_I;
            last_q    <= OWN_I;
            op_wr_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (grant) begin
                owner_q <= grant_d ? OWN_D : OWN_I;
                op_wr_q <= grant_wr;
                addr_q  <= align_addr(grant_d ? bus.d_addr : bus.i_addr);
                if (grant_wr) wdata_q <= bus.d_wdata;
            end
            if (capture) begin
                last_q <= owner_q;
                if (!op_wr_q) begin
                    if (owner_q == OWN_D) d_rdata_q <= bus.pmem_rdata;
                    else                  i_rdata_q <= bus.pmem_rdata;
                end
            end
        end
    end

    assign bus.pmem_read    = (state_q == SERVE) && !op_wr_q;
    assign bus.pmem_write   = (state_q == SERVE) &&  op_wr_q;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;

    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.i_resp  = (state_q == RESP) && (owner_q == OWN_I);
    assign bus.d_resp  = (state_q == RESP) && (owner_q == OWN_D);

endmodule

// File: tb/tb_line_mem_arbiter.sv
// Directed bench for line_mem_arbiter: reset, single reads/writes, round-robin,
// queued requests, asynchronous reset and stray memory responses.
module tb_line_mem_arbiter;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    line_mem_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

    line_mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Called at the falling edge of a SERVE cycle; memory answers in that cycle.
    task automatic serve_one(input string tag, input bit is_d, input bit is_wr,
                             input logic [ADDR_W-1:0] exp_addr,
                             input logic [LINE_W-1:0] line,
                             input logic [LINE_W-1:0] exp_wdata);
        chk({tag, "_pmem_read"}, bus.pmem_read, !is_wr);
        chk({tag, "_pmem_write"}, bus.pmem_write, is_wr);
        chk({tag, "_pmem_address"}, bus.pmem_address, exp_addr);
        if (is_wr) chk({tag, "_pmem_wdata"}, bus.pmem_wdata, exp_wdata);
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = line;
        step();
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = {8{32'hDEAD_BEEF}};
        chk({tag, "_i_resp"}, bus.i_resp, !is_d);
        chk({tag, "_d_resp"}, bus.d_resp, is_d);
        chk({tag, "_pmem_drop"}, {bus.pmem_read, bus.pmem_write}, 2'b00);
        if (!is_wr) begin
            if (is_d) chk({tag, "_d_rdata"}, bus.d_rdata, line);
            else      chk({tag, "_i_rdata"}, bus.i_rdata, line);
        end
        if (is_d) begin
            bus.d_read  = 1'b0;
            bus.d_write = 1'b0;
        end else begin
            bus.i_read = 1'b0;
        end
        step();
        chk({tag, "_resp_done"}, {bus.i_resp, bus.d_resp}, 2'b00);
        chk({tag, "_idle"}, {bus.pmem_read, bus.pmem_write}, 2'b00);
    endtask

    always @(negedge clk) begin
        if (bus.d_read === 1'b1 && bus.d_write === 1'b1) begin
            n_chk++;
            n_fail++;
            $error("FAIL illegal_d_rw: observed d_read=1 d_write=1 required not both");
        end
    end

    initial begin
        logic [LINE_W-1:0] line_aa, wline, l1, l2, l3, l4, l5, l6, rnd;
        n_chk  = 0;
        n_fail = 0;
        line_aa = {32{8'hAA}};
        wline   = {8{32'h1234_5678}};
        l1      = {16{16'hD00D}};
        l2      = {16{16'h1CE1}};
        l3      = {8{32'h0BAD_F00D}};
        l4      = {8{32'hC0FF_EE00}};
        l5      = {4{64'h0123_4567_89AB_CDEF}};
        l6      = {4{64'hFEDC_BA98_7654_3210}};

        rst            = 1'b0;
        bus.i_read     = 1'b0;
        bus.i_addr     = '0;
        bus.d_read     = 1'b0;
        bus.d_write    = 1'b0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.pmem_rdata = '0;
        bus.pmem_resp  = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_pmem_read", bus.pmem_read, 1'b0);
        chk("rst_pmem_write", bus.pmem_write, 1'b0);
        chk("rst_pmem_address", bus.pmem_address, '0);
        chk("rst_pmem_wdata", bus.pmem_wdata, '0);
        chk("rst_i_rdata", bus.i_rdata, '0);
        chk("rst_d_rdata", bus.d_rdata, '0);
        chk("rst_resp", {bus.i_resp, bus.d_resp}, 2'b00);
        rst = 1'b1;
        step();
        chk("idle_no_req", {bus.pmem_read, bus.pmem_write}, 2'b00);

        // I-only read with a two-cycle memory
        bus.i_read = 1'b1;
        bus.i_addr = 32'h0000_0064;
        step();
        chk("t1_first_read", bus.pmem_read, 1'b1);
        chk("t1_first_addr", bus.pmem_address, 32'h0000_0060);
        step();
        serve_one("t1", 1'b0, 1'b0, 32'h0000_0060, line_aa, '0);

        // D writeback; returned memory data must not reach d_rdata
        bus.d_write = 1'b1;
        bus.d_addr  = 32'h0000_1040;
        bus.d_wdata = wline;
        step();
        serve_one("t2", 1'b1, 1'b1, 32'h0000_1040, {32{8'h55}}, wline);
        chk("t2_d_rdata_kept", bus.d_rdata, '0);
        chk("t2_i_rdata_kept", bus.i_rdata, line_aa);

        // Asynchronous reset in the middle of SERVE
        bus.i_read = 1'b1;
        bus.i_addr = 32'h0000_0300;
        step();
        chk("ar_pmem_read_before", bus.pmem_read, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("ar_pmem_read_async", bus.pmem_read, 1'b0);
        chk("ar_pmem_address", bus.pmem_address, '0);
        chk("ar_i_rdata", bus.i_rdata, '0);
        bus.i_read = 1'b0;
        step();
        rst = 1'b1;
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = {32{8'h77}};
        step();
        chk("ar_stray_resp", {bus.i_resp, bus.d_resp}, 2'b00);
        chk("ar_stray_pmem", {bus.pmem_read, bus.pmem_write}, 2'b00);
        chk("ar_stray_i_rdata", bus.i_rdata, '0);
        chk("ar_stray_d_rdata", bus.d_rdata, '0);
        bus.pmem_resp = 1'b0;
        step();

        // Simultaneous pair after reset: D first, then I
        bus.i_read = 1'b1;
        bus.i_addr = 32'h0000_0100;
        bus.d_read = 1'b1;
        bus.d_addr = 32'h0000_0200;
        step();
        serve_one("p1d", 1'b1, 1'b0, 32'h0000_0200, l1, '0);
        step();
        serve_one("p1i", 1'b0, 1'b0, 32'h0000_0100, l2, '0);

        // D request arrives while I is being served
        bus.i_read = 1'b1;
        bus.i_addr = 32'h0000_0400;
        step();
        chk("mt_i_addr", bus.pmem_address, 32'h0000_0400);
        bus.d_read = 1'b1;
        bus.d_addr = 32'h0000_0500;
        step();
        serve_one("mti", 1'b0, 1'b0, 32'h0000_0400, l3, '0);
        step();
        serve_one("mtd", 1'b1, 1'b0, 32'h0000_0500, l4, '0);

        // Second simultaneous pair after a D service: I first, then D
        bus.i_read = 1'b1;
        bus.i_addr = 32'h0000_061F;
        bus.d_read = 1'b1;
        bus.d_addr = 32'h0000_07E5;
        step();
        serve_one("p2i", 1'b0, 1'b0, 32'h0000_0600, l5, '0);
        step();
        serve_one("p2d", 1'b1, 1'b0, 32'h0000_07E0, l6, '0);

        // Stray pmem_resp in IDLE
        for (int k = 0; k < LINE_W / 32; k++) rnd[k*32 +: 32] = $urandom();
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = rnd;
        step();
        chk("st_resp", {bus.i_resp, bus.d_resp}, 2'b00);
        chk("st_pmem", {bus.pmem_read, bus.pmem_write}, 2'b00);
        chk("st_i_rdata", bus.i_rdata, l5);
        chk("st_d_rdata", bus.d_rdata, l6);
        bus.pmem_resp = 1'b0;
        step();
        chk("st_resp_after", {bus.i_resp, bus.d_resp}, 2'b00);
        chk("st_i_rdata_after", bus.i_rdata, l5);
        chk("st_d_rdata_after", bus.d_rdata, l6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
